flit_link_tx: RTL
=================

Name: flit_link_tx

Overview:
- Drain side of a router input buffer in the 2x2 mesh.
- Pulls flits out of the local 8-deep, 8-bit flit FIFO using single-cycle read pulses.
- Drives them onto the inter-router link as a valid/data pair.
- Honours credit-based flow control from the downstream router's input FIFO, so no flit is sent without a free downstream slot.

Parameters:
- DATA_W, 8, flit width in bits.
- CREDITS, 8, downstream FIFO depth; credit counter reset value and ceiling.
- CNT_W, 4, credit counter width; must hold 0..CREDITS.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  local FIFO holds no flits; may lag a read by one cycle.
- fifo_read  output  1  registered single-cycle read strobe to the local FIFO.
- fifo_data  input  DATA_W  local FIFO registered read data; valid from the edge that samples fifo_read.
- link_valid  output  1  registered; flit on link_data this cycle, one cycle wide.
- link_data  output  DATA_W  registered flit to the downstream router.
- link_credit  input  1  one-cycle pulse; one downstream slot freed.
- credit_err  output  1  sticky; a credit was returned while the counter was already at CREDITS.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, credits=CREDITS.
  - fifo_read=0, link_valid=0, link_data=0, credit_err=0.
  - A reset in the middle of a transfer drops any fetched but unsent flit, with no link_valid.
- FSM states: IDLE, RD, CAP.
  - IDLE -> RD when fifo_empty=0 and credits>0. The transition edge sets fifo_read<=1 and decrements credits (slot reserved).
  - RD -> CAP unconditionally; fifo_read<=0. The FIFO samples the read on this edge.
  - CAP: on the leaving edge, link_data<=fifo_data and link_valid<=1 for exactly one cycle.
  - CAP -> RD if fifo_empty=0 and credits>0, with fifo_read<=1 and credits decremented; otherwise CAP -> IDLE.
- Throughput: at most one flit per 2 cycles. fifo_read is never high on two consecutive cycles, because the FIFO's empty flag lags by one cycle.
- Latency: fifo_read rises at edge k; link_valid is high in the cycle after edge k+2.
- Credit arithmetic, evaluated per edge:
  - reserve only: credits-1.
  - link_credit only: credits+1.
  - reserve and link_credit together: credits unchanged.
  - link_credit at credits=CREDITS with no reserve: value held, credit_err<=1 (sticky until rst).
- Credits reach 0 only through reservations, never by underflow. At credits=0 the FSM stays in IDLE until a link_credit arrives; a credit arriving in the same cycle permits the transition on the next edge.
- fifo_empty is sampled only in IDLE and CAP.
- link_data holds its last value when link_valid=0.

Optional Feature:
- Macro: FLIT_LINK_TX_PARITY_EN.
- Defined:
  - Adds output link_parity (1 bit): even parity (XOR) over the fifo_data being captured.
  - Registered together with link_data, so it is valid with link_valid.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package noc_pkg holds:
  - DATA_W, CREDITS, CNT_W defaults.
  - FSM state encoding: IDLE=2'd0, RD=2'd1, CAP=2'd2.
- Natural sub-module: credit_counter.
  - Inputs: dec (the reserve strobe), inc (link_credit).
  - Outputs: credits, nonzero, err.
  - Carries its own async reset to CREDITS.
- The FSM and output registers stay in flit_link_tx.

Test Plan:
1. Reset check:
   - Stimulus: rst pulse mid-cycle with fifo_empty=0.
   - Response: all outputs 0 asynchronously, credits=8; after release the first fifo_read occurs on the first clock edge.
2. Single flit:
   - Stimulus: fifo_empty=0 for one read, fifo_data=8'hA5 after the read.
   - Response: link_valid high for 1 cycle, 2 cycles after fifo_read, with link_data=8'hA5; credits=7.
3. Credit exhaustion:
   - Stimulus: fifo_empty held 0, no link_credit.
   - Response: exactly 8 link_valid pulses, spaced 2 cycles apart, then idle with fifo_read=0.
   - Then: a single link_credit pulse yields exactly one more flit.
4. Simultaneous credit and reserve:
   - Stimulus: link_credit asserted on the same edge as the CAP->RD transition, at credits=3.
   - Response: credits stays 3.
5. Credit overflow:
   - Stimulus: link_credit at credits=8 while idle.
   - Response: credits stays 8, credit_err=1, and stays 1 until rst.
6. Parity (with FLIT_LINK_TX_PARITY_EN defined):
   - Stimulus: send flits 8'h07 and 8'h03.
   - Response: link_parity=1 with the first, 0 with the second.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and FSM encoding for the mesh router link logic.
package noc_pkg;

  localparam int unsigned DATA_W  = 8;  // flit width in bits
  localparam int unsigned CREDITS = 8;  // downstream FIFO depth
  localparam int unsigned CNT_W   = 4;  // must hold 0..CREDITS

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_e;

  // Even parity over one flit (XOR reduction).
  function automatic logic flit_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream credit tracker: one credit per free slot in the neighbour's
// input FIFO. A reserve and a returned credit on the same edge cancel.
module credit_counter
  import noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] credits,
  output logic             nonzero,
  output logic             err
);

  logic [CNT_W-1:0] credits_q, credits_d;
  logic             nonzero_q;
  logic             err_q, err_d;

  // Next credit count and sticky overflow flag.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({dec, inc})
      2'b10: credits_d = credits_q - CNT_W'(1);
      2'b01: begin
        if (credits_q == CNT_W'(CREDITS)) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Counter registers; nonzero is registered alongside the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CNT_W'(CREDITS);
      nonzero_q <= (CREDITS != 0);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      nonzero_q <= (credits_d != '0);
      err_q     <= err_d;
    end
  end

  assign credits = credits_q;
  assign nonzero = nonzero_q;
  assign err     = err_q;

endmodule

// File: rtl/flit_link_tx.sv
// Link transmitter: drains the local flit FIFO onto the inter-router link
// under credit flow control. Optional link parity output is enabled by
// defining FLIT_LINK_TX_PARITY_EN.
module flit_link_tx
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              link_valid,
  output logic [DATA_W-1:0] link_data,
  input  logic              link_credit,
`ifdef FLIT_LINK_TX_PARITY_EN
  output logic              link_parity,
`endif
  output logic              credit_err
);

  state_e            state_q;
  logic              fifo_read_q;
  logic              link_valid_q;
  logic [DATA_W-1:0] link_data_q;
  logic [CNT_W-1:0]  credits;
  logic              credit_nz;
  logic              reserve_c;

  // A slot is reserved whenever the FSM may start a read and a credit exists.
  assign reserve_c = ((state_q == IDLE) || (state_q == CAP)) && !fifo_empty && credit_nz;

  credit_counter u_credit (
    .clk     (clk),
    .rst     (rst),
    .dec     (reserve_c),
    .inc     (link_credit),
    .credits (credits),
    .nonzero (credit_nz),
    .err     (credit_err)
  );

  // Transfer FSM with registered read strobe and link outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fifo_read_q  <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
    end else begin
      fifo_read_q  <= 1'b0;
      link_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reserve_c) begin
            state_q     <= RD;
            fifo_read_q <= 1'b1;
          end
        end
        RD: begin
          state_q <= CAP;
        end
        CAP: begin
          link_data_q  <= fifo_data;
          link_valid_q <= 1'b1;
          if (reserve_c) begin
            state_q     <= RD;
            fifo_read_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FLIT_LINK_TX_PARITY_EN
  logic link_parity_q;

  // Parity captured on the same edge as link_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_parity_q <= 1'b0;
    end else if (state_q == CAP) begin
      link_parity_q <= flit_parity(fifo_data);
    end
  end

  assign link_parity = link_parity_q;
`endif

  assign fifo_read  = fifo_read_q;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;

  // Credit count never exceeds the ceiling and the nonzero flag tracks it.
  a_credit_bounds : assert property (@(posedge clk) disable iff (rst)
    (credits <= CNT_W'(CREDITS)) && (credit_nz == (credits != '0)));

endmodule
